// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
package bus_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned SEL_W_DEF  = 4;
  localparam int unsigned MAX_REGS   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index to one-hot; indices at or beyond MAX_REGS shift out to zero.
  function automatic logic [MAX_REGS-1:0] onehot_dec(input int unsigned idx);
    return MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/sel_decode.sv
// Register index to one-hot select, with an enable and an out-of-range flag.
module sel_decode
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot_c,
  output logic                oor_c
);

  // Out-of-range indices never produce a select bit.
  assign oor_c    = (32'(sel) >= NUM_REGS);
  assign onehot_c = (en && !oor_c) ? NUM_REGS'(onehot_dec(32'(sel))) : '0;

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-to-register transfer sequencer for the shared data bus.
// Drives the source output enable, pulses the destination load enable,
// and snoops the bus on the load cycle.
// Optional macro XFER_IMM_EN: source index NUM_REGS selects an external
// immediate driver via imm_oe instead of a register output enable.
module bus_xfer_seq
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [SEL_W-1:0]    src_sel,
  input  logic [SEL_W-1:0]    dst_sel,
  output logic                ready,
  output logic                ack,
  output logic                err,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] in_en,
  input  logic [DATA_W-1:0]   bus,
`ifdef XFER_IMM_EN
  output logic                imm_oe,
  input  logic [DATA_W-1:0]   imm_data,
`endif
  output logic [DATA_W-1:0]   last_data
);

  state_e              state;
  logic [NUM_REGS-1:0] src_oh, dst_oh;
  logic [NUM_REGS-1:0] src_q, dst_q;
  logic                src_oor, dst_oor;
  logic                src_ok, accept, valid;
  logic                pend_err;

  sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_src_dec (
    .sel      (src_sel),
    .en       (accept),
    .onehot_c (src_oh),
    .oor_c    (src_oor)
  );

  sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dst_dec (
    .sel      (dst_sel),
    .en       (accept),
    .onehot_c (dst_oh),
    .oor_c    (dst_oor)
  );

`ifdef XFER_IMM_EN
  logic src_imm;
  logic imm_q;
  logic imm_unused;

  // The immediate value is driven onto the bus outside this block.
  assign imm_unused = ^imm_data;
  assign src_imm    = (32'(src_sel) == NUM_REGS);
  assign src_ok     = !src_oor || src_imm;
`else
  assign src_ok     = !src_oor;
`endif

  // Request acceptance and validation of the live select inputs.
  assign accept = ready && req;
  assign valid  = src_ok && !dst_oor && (src_sel != dst_sel);

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      ack       <= 1'b0;
      err       <= 1'b0;
      oe        <= '0;
      in_en     <= '0;
      last_data <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pend_err  <= 1'b0;
`ifdef XFER_IMM_EN
      imm_q     <= 1'b0;
      imm_oe    <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      oe    <= '0;
      in_en <= '0;
`ifdef XFER_IMM_EN
      imm_oe <= 1'b0;
`endif
      // Snoop the bus at the end of the cycle the load enable is visible.
      if (|in_en) last_data <= bus;

      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            ready <= 1'b0;
            src_q <= src_oh;
            dst_q <= dst_oh;
`ifdef XFER_IMM_EN
            imm_q <= src_imm;
`endif
            if (valid) begin
              state <= DRIVE;
            end else begin
              pend_err <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DRIVE: begin
          oe    <= src_q;
`ifdef XFER_IMM_EN
          imm_oe <= imm_q;
`endif
          state <= LATCH;
        end
        LATCH: begin
          oe    <= src_q;
          in_en <= dst_q;
`ifdef XFER_IMM_EN
          imm_oe <= imm_q;
`endif
          state <= DONE;
        end
        DONE: begin
          ack      <= 1'b1;
          err      <= pend_err;
          pend_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
